// File: rtl/seg7_scan_capture.sv
// Readback of a multiplexed 4-digit 7-segment scan into a 16-bit value.
// SEG_CAPTURE_BLANK_EN: accept the all-off pattern as a blank digit.
module seg7_scan_capture #(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  AN,
  input  logic [7:0]  SEG,
  input  logic        err_clr,
  output logic [15:0] dat,
  output logic [3:0]  dp,
  output logic        frame_vld,
  output logic        seg_err,
  output logic        stale
`ifdef SEG_CAPTURE_BLANK_EN
  ,
  output logic [3:0]  blank
`endif
);

  localparam int SW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t state_q;

  logic [3:0]    an_s1_q, an_s2_q, an_p_q;
  logic [7:0]    seg_s1_q, seg_s2_q, seg_p_q;
  logic [SW-1:0] stab_q;
  logic [TW-1:0] idle_q;
  logic [15:0]   nib_q, nib_d;
  logic [3:0]    pt_q, pt_d;
  logic [3:0]    seen_q, seen_d;
  logic [15:0]   dat_q;
  logic [3:0]    dp_q;
  logic          frame_vld_q;
  logic          seg_err_q;
  logic          stale_q;

  logic          sel_vld;
  logic [1:0]    idx;
  logic          dec_ok;
  logic [3:0]    dec_nib;
  logic          chg;
  logic          acc;

`ifdef SEG_CAPTURE_BLANK_EN
  logic          dec_blank;
  logic [3:0]    blk_q, blk_d;
  logic [3:0]    blank_q;
`endif

  always_comb begin
    sel_vld = 1'b0;
    idx     = 2'd0;
    case (an_s2_q)
      4'b1110: begin sel_vld = 1'b1; idx = 2'd0; end
      4'b1101: begin sel_vld = 1'b1; idx = 2'd1; end
      4'b1011: begin sel_vld = 1'b1; idx = 2'd2; end
      4'b0111: begin sel_vld = 1'b1; idx = 2'd3; end
      default: ;
    endcase
  end

  // Active-low segment patterns, SEG[6:0] = g..a
  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
`ifdef SEG_CAPTURE_BLANK_EN
    dec_blank = 1'b0;
`endif
    case (seg_s2_q[6:0])
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h03: dec_nib = 4'hB;
      7'h46: dec_nib = 4'hC;
      7'h21: dec_nib = 4'hD;
      7'h06: dec_nib = 4'hE;
      7'h0E: dec_nib = 4'hF;
`ifdef SEG_CAPTURE_BLANK_EN
      7'h7F: dec_blank = 1'b1;
`endif
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    chg = {an_s2_q, seg_s2_q} != {an_p_q, seg_p_q};
    acc = (state_q == SETTLE) && sel_vld && !chg
          && (stab_q == STAB_LAST);
    nib_d = nib_q;
    nib_d[{idx, 2'b00} +: 4] = dec_nib;
    pt_d = pt_q;
    pt_d[idx] = ~seg_s2_q[7];
    seen_d = seen_q;
    seen_d[idx] = 1'b1;
`ifdef SEG_CAPTURE_BLANK_EN
    blk_d = blk_q;
    blk_d[idx] = dec_blank;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s1_q     <= 4'hF;
      an_s2_q     <= 4'hF;
      an_p_q      <= 4'hF;
      seg_s1_q    <= 8'hFF;
      seg_s2_q    <= 8'hFF;
      seg_p_q     <= 8'hFF;
      state_q     <= IDLE;
      stab_q      <= '0;
      idle_q      <= '0;
      nib_q       <= '0;
      pt_q        <= '0;
      seen_q      <= '0;
      dat_q       <= '0;
      dp_q        <= '0;
      frame_vld_q <= 1'b0;
      seg_err_q   <= 1'b0;
      stale_q     <= 1'b0;
`ifdef SEG_CAPTURE_BLANK_EN
      blk_q       <= '0;
      blank_q     <= '0;
`endif
    end else begin
      an_s1_q     <= AN;
      an_s2_q     <= an_s1_q;
      an_p_q      <= an_s2_q;
      seg_s1_q    <= SEG;
      seg_s2_q    <= seg_s1_q;
      seg_p_q     <= seg_s2_q;
      frame_vld_q <= 1'b0;

      if (acc && !dec_ok) seg_err_q <= 1'b1;
      else if (err_clr)   seg_err_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (sel_vld) begin
            state_q <= SETTLE;
            stab_q  <= '0;
          end
        end
        SETTLE: begin
          if (!sel_vld)                state_q <= IDLE;
          else if (chg)                stab_q  <= '0;
          else if (stab_q == STAB_LAST) state_q <= HOLD;
          else                         stab_q  <= stab_q + 1'b1;
        end
        HOLD: begin
          if (chg) begin
            state_q <= sel_vld ? SETTLE : IDLE;
            stab_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (acc) begin
        idle_q <= '0;
        if (dec_ok) begin
          nib_q <= nib_d;
          pt_q  <= pt_d;
`ifdef SEG_CAPTURE_BLANK_EN
          blk_q <= blk_d;
`endif
          if (&seen_d) begin
            dat_q       <= nib_d;
            dp_q        <= pt_d;
            frame_vld_q <= 1'b1;
            seen_q      <= '0;
            stale_q     <= 1'b0;
`ifdef SEG_CAPTURE_BLANK_EN
            blank_q     <= blk_d;
`endif
          end else begin
            seen_q <= seen_d;
          end
        end
      end else if (idle_q == TO_LAST) begin
        // Scan silent too long: drop any partial frame
        stale_q <= 1'b1;
        seen_q  <= '0;
      end else begin
        idle_q <= idle_q + 1'b1;
      end
    end
  end

  assign dat       = dat_q;
  assign dp        = dp_q;
  assign frame_vld = frame_vld_q;
  assign seg_err   = seg_err_q;
  assign stale     = stale_q;
`ifdef SEG_CAPTURE_BLANK_EN
  assign blank     = blank_q;
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with an event-level scan model.
module tb_seg7_scan_capture;
  localparam int STB = 16;
  localparam int TO  = 300;
  localparam int LAT = STB + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  AN;
  logic [7:0]  SEG;
  logic        err_clr;
  logic [15:0] dat;
  logic [3:0]  dp;
  logic        frame_vld, seg_err, stale;
`ifdef SEG_CAPTURE_BLANK_EN
  logic [3:0]  blank;
`endif

  seg7_scan_capture #(.STABLE_CYC(STB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .AN(AN), .SEG(SEG), .err_clr(err_clr),
    .dat(dat), .dp(dp), .frame_vld(frame_vld), .seg_err(seg_err),
    .stale(stale)
`ifdef SEG_CAPTURE_BLANK_EN
    , .blank(blank)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int n_fv = 0;

  logic [6:0] enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                           7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                           7'h46, 7'h21, 7'h06, 7'h0E};

  // kind: 0 = digit stored, 1 = undecodable, 2 = error clear
  typedef struct {
    int         c;
    int         kind;
    int         d;
    logic [3:0] n;
    logic       p;
  } ev_t;
  ev_t evq[$];

  logic [3:0]  m_nib [4];
  logic        m_pt  [4];
  logic        m_seen[4];
  logic [15:0] m_dat;
  logic [3:0]  m_dp;
  logic        m_err, m_stale, m_fv;
  int          m_last;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: actual=%0h required=%0h",
               nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_nib[k] = 4'h0; m_pt[k] = 1'b0; m_seen[k] = 1'b0;
      end
      m_dat = '0; m_dp = '0; m_err = 1'b0; m_stale = 1'b0;
      m_last = cyc;
      evq.delete();
    end else begin
      m_fv = 1'b0;
      for (int k = 0; k < evq.size(); ) begin
        if (evq[k].c == cyc) begin
          if (evq[k].kind == 0) begin
            m_last = cyc;
            m_nib[evq[k].d] = evq[k].n;
            m_pt[evq[k].d] = evq[k].p;
            m_seen[evq[k].d] = 1'b1;
            if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
              m_dat = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
              m_dp  = {m_pt[3], m_pt[2], m_pt[1], m_pt[0]};
              m_fv = 1'b1;
              m_stale = 1'b0;
              for (int j = 0; j < 4; j++) m_seen[j] = 1'b0;
            end
          end else if (evq[k].kind == 1) begin
            m_last = cyc;
            m_err = 1'b1;
          end else begin
            m_err = 1'b0;
          end
          evq.delete(k);
        end else begin
          k++;
        end
      end
      if (cyc - m_last >= TO) begin
        m_stale = 1'b1;
        for (int j = 0; j < 4; j++) m_seen[j] = 1'b0;
      end
      if (frame_vld) n_fv++;
      chk("frame_vld", 32'(frame_vld), 32'(m_fv));
      chk("dat", 32'(dat), 32'(m_dat));
      chk("dp", 32'(dp), 32'(m_dp));
      chk("seg_err", 32'(seg_err), 32'(m_err));
      chk("stale", 32'(stale), 32'(m_stale));
    end
  end

  task automatic raw(input logic [3:0] an, input logic [7:0] seg,
                     input int dwell);
    ev_t e;
    int zeros, d, nn;
    AN = an;
    SEG = seg;
    zeros = 0; d = 0; nn = -1;
    for (int i = 0; i < 4; i++)
      if (!an[i]) begin zeros++; d = i; end
    if (zeros == 1 && dwell >= LAT) begin
      for (int k = 0; k < 16; k++)
        if (enc[k] == seg[6:0]) nn = k;
`ifdef SEG_CAPTURE_BLANK_EN
      if (seg[6:0] == 7'h7F) nn = 0;
`endif
      e.c = cyc + LAT;
      e.d = d;
      e.p = ~seg[7];
      e.n = 4'(nn);
      e.kind = (nn < 0) ? 1 : 0;
      evq.push_back(e);
    end
    repeat (dwell) @(negedge clk);
  endtask

  task automatic dig(input int i, input int n, input bit p,
                     input int dwell);
    logic [3:0] a;
    a = 4'hF;
    a[i] = 1'b0;
    raw(a, {~p, enc[n]}, dwell);
  endtask

  task automatic clr_err();
    ev_t e;
    err_clr = 1'b1;
    e.c = cyc + 1; e.kind = 2; e.d = 0; e.n = 4'h0; e.p = 1'b0;
    evq.push_back(e);
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic reset_pulse();
    #1;
    rst = 1'b1;
    AN = 4'hF;
    SEG = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_dat", 32'(dat), 32'h0);
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_fv", 32'(frame_vld), 32'h0);
    chk("rst_err", 32'(seg_err), 32'h0);
    chk("rst_stale", 32'(stale), 32'h0);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    AN = 4'hF;
    SEG = 8'hFF;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_dat", 32'(dat), 32'h0);
    chk("init_fv", 32'(frame_vld), 32'h0);
    chk("init_stale", 32'(stale), 32'h0);
    #1;
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 2; r++) begin
      dig(0, 4, 0, 40); dig(1, 3, 0, 40);
      dig(2, 2, 0, 40); dig(3, 1, 0, 40);
    end
    chk("scan1234_dat", 32'(dat), 32'h1234);
    chk("scan1234_dp", 32'(dp), 32'h0);

    for (int t = 0; t < 20; t++)
      dig(1, (t % 2 == 0) ? 10 : 8, 0, 5);
    dig(1, 10, 0, 40);
    dig(0, 5, 0, 40); dig(2, 6, 0, 40); dig(3, 7, 0, 40);
    chk("glitch_dat", 32'(dat), 32'h76A5);
    chk("glitch_err", 32'(seg_err), 32'h0);

    dig(0, 1, 0, 40); dig(1, 2, 0, 40);
    raw(4'b1011, 8'hFF, 40);
    dig(3, 3, 0, 40);
    chk("bad_err", 32'(seg_err), 32'h1);
    chk("bad_dat", 32'(dat), 32'h76A5);
    raw(4'hF, 8'hFF, 2);
    clr_err();
    chk("clr_err", 32'(seg_err), 32'h0);

    raw(4'hF, 8'hFF, TO + 20);
    chk("stale_set", 32'(stale), 32'h1);
    chk("stale_dat", 32'(dat), 32'h76A5);
    dig(2, 12, 0, 40); dig(3, 13, 0, 40);
    dig(0, 14, 0, 40); dig(1, 15, 0, 40);
    chk("resume_stale", 32'(stale), 32'h0);
    chk("resume_dat", 32'(dat), 32'hDCFE);

    raw(4'b1100, {1'b1, enc[8]}, 100);
    dig(0, 9, 0, 40); dig(1, 8, 0, 40);
    dig(2, 0, 0, 40); dig(3, 5, 1, 40);
    chk("dp3_dp", 32'(dp), 32'h8);
    chk("dp3_dat", 32'(dat), 32'h5089);

    dig(0, 1, 0, 40); dig(1, 2, 0, 40); dig(2, 3, 0, 40);
    reset_pulse();
    dig(3, 4, 0, 40);
    chk("post_rst_dat", 32'(dat), 32'h0);
    dig(0, 8, 0, 40); dig(1, 7, 0, 40); dig(2, 6, 0, 40);
    chk("post_rst_frame", 32'(dat), 32'h4678);

    raw(4'hF, 8'hFF, 30);
    chk("frame_count", 32'(n_fv), 32'd6);
    chk("events_drained", 32'(evq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
